// File: rtl/fir_sample_src.sv
// fir_sample_src: plays a host-loaded sequence of signed samples onto a FIR
// input through a valid/ready handshake, one-shot or looped, with abort.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no sequence active; Xout/Xvalid held at 0, Start honoured
// PLAY  | presenting mem[ptr] on Xout, advancing on each handshake
module fir_sample_src #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Wr_en,
  input  logic [AW-1:0] Wr_addr,
  input  logic [DW-1:0] Wr_data,
  input  logic [AW:0]   Len,
  input  logic          Start,
  input  logic          Loop,
  input  logic          Stop,
  output logic [DW-1:0] Xout,
  output logic          Xvalid,
  input  logic          Xready,
  output logic          Busy,
  output logic          Done,
  output logic [15:0]   Sent
);

  localparam int LW = AW + 1;
  localparam logic [LW-1:0] depth_l = LW'(DEPTH);
  localparam logic [LW-1:0] one_l   = LW'(1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr, ptr_nxt;
  logic [LW-1:0] len_q, len_clamped;
  logic          loop_q;
  logic [DW-1:0] xout_q;
  logic          done_q;
  logic          hs, last, start_ok, finish;

  assign hs          = (state == PLAY) && Xready;
  assign last        = ({1'b0, ptr} == (len_q - one_l));
  assign start_ok    = Start && (Len != '0);
  assign len_clamped = (Len > depth_l) ? depth_l : Len;
  assign ptr_nxt     = last ? '0 : (ptr + AW'(1));
  assign finish      = hs && last && !loop_q;

  // Sample buffer: written in any state, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Wr_en) begin
      mem[Wr_addr] <= Wr_data;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: Start only from IDLE, Stop or one-shot end from PLAY.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = PLAY;
      PLAY: if (Stop || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Playback datapath. The presented sample is captured into xout_q at each
  // advance so a write to the entry on display cannot disturb a stalled Xout.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ptr    <= '0;
      len_q  <= '0;
      loop_q <= 1'b0;
      xout_q <= '0;
      done_q <= 1'b0;
      Sent   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          len_q  <= len_clamped;
          loop_q <= Loop;
          ptr    <= '0;
          Sent   <= '0;
          xout_q <= mem[0];
        end
      end else begin
        if (hs) begin
          if (Sent != 16'hFFFF) Sent <= Sent + 16'd1;
          ptr    <= ptr_nxt;
          xout_q <= mem[ptr_nxt];
        end
        if (Stop || finish) done_q <= 1'b1;
      end
    end
  end

  // Output decode: zeros whenever no sequence is playing.
  always_comb begin
    Xvalid = (state == PLAY);
    Busy   = (state == PLAY);
    Xout   = (state == PLAY) ? xout_q : '0;
    Done   = done_q;
  end

endmodule

// File: tb/tb_fir_sample_src.sv
// Testbench for fir_sample_src: directed scenarios followed by random traffic,
// every cycle compared against a handshake-count reference model.
module tb_fir_sample_src;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LW = AW + 1;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst_n, Wr_en, Start, Loop, Stop, Xready;
  logic [AW-1:0] Wr_addr;
  logic [DW-1:0] Wr_data;
  logic [LW-1:0] Len;
  logic [DW-1:0] Xout;
  logic          Xvalid, Busy, Done;
  logic [15:0]   Sent;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit            m_play;
  int            m_k, m_len, m_sent;
  bit            m_loop, m_done;
  logic [DW-1:0] m_cur;
  logic [DW-1:0] m_mem [DEPTH];

  always #5 Clk = ~Clk;

  fir_sample_src #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
    .Wr_data(Wr_data), .Len(Len), .Start(Start), .Loop(Loop), .Stop(Stop),
    .Xout(Xout), .Xvalid(Xvalid), .Xready(Xready), .Busy(Busy),
    .Done(Done), .Sent(Sent)
  );

  // Model: sample k of a sequence is entry (k mod len); a one-shot ends once
  // len samples have been accepted.
  task automatic model_edge();
    bit fin;
    if (!Rst_n) begin
      m_play = 0; m_k = 0; m_len = 0; m_loop = 0; m_cur = '0;
      m_done = 0; m_sent = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_done = 0;
      fin = 0;
      if (!m_play) begin
        if (Start && Len != '0) begin
          m_len  = (int'(Len) > DEPTH) ? DEPTH : int'(Len);
          m_loop = Loop;
          m_k    = 0;
          m_sent = 0;
          m_cur  = m_mem[0];
          m_play = 1;
        end
      end else begin
        if (Xready) begin
          m_k++;
          if (m_sent < 65535) m_sent++;
          if (!m_loop && m_k == m_len) fin = 1;
          else m_cur = m_mem[m_k % m_len];
        end
        if (Stop || fin) begin
          m_play = 0;
          m_done = 1;
        end
      end
      if (Wr_en) m_mem[Wr_addr] = Wr_data;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("xvalid", 32'(Xvalid), 32'(m_play));
    chk("busy",   32'(Busy),   32'(m_play));
    chk("xout",   32'(Xout),   32'(m_play ? m_cur : 8'h00));
    chk("done",   32'(Done),   32'(m_done));
    chk("sent",   32'(Sent),   32'(m_sent));
  endtask

  task automatic wr(input int addr, input int data);
    Wr_en = 1'b1;
    Wr_addr = AW'(addr);
    Wr_data = DW'(data);
    step();
    Wr_en = 1'b0;
  endtask

  task automatic start_seq(input int len, input bit lp);
    Start = 1'b1;
    Len = LW'(len);
    Loop = lp;
    step();
    Start = 1'b0;
  endtask

  logic [DW-1:0] golden [10] = '{8'h00, 8'hFD, 8'h01, 8'h00, 8'hFE,
                                 8'hFF, 8'h04, 8'hFB, 8'h06, 8'h00};
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    Rst_n = 1'b0; Wr_en = 1'b0; Wr_addr = '0; Wr_data = '0; Len = '0;
    Start = 1'b0; Loop = 1'b0; Stop = 1'b0; Xready = 1'b1;
    step();
    step();
    chk("rst_xvalid", 32'(Xvalid), 32'd0);
    chk("rst_sent", 32'(Sent), 32'd0);
    Rst_n = 1'b1;
    step();

    // one-shot, Xready=1
    for (int i = 0; i < 10; i++) wr(i, int'(golden[i]));
    start_seq(10, 0);
    for (int i = 0; i < 10; i++) begin
      chk("oneshot_seq", 32'(Xout), 32'(golden[i]));
      step();
    end
    chk("oneshot_done", 32'(Done), 32'd1);
    chk("oneshot_sent", 32'(Sent), 32'd10);
    chk("oneshot_xout", 32'(Xout), 32'd0);
    step();
    chk("oneshot_done_pulse", 32'(Done), 32'd0);

    // backpressure 1,0,0,1,...
    start_seq(10, 0);
    for (int c = 0; c < 60 && !Done; c++) begin
      Xready = bp_pat[c % 4];
      step();
    end
    chk("bp_done_seen", 32'(Done), 32'd1);
    chk("bp_sent", 32'(Sent), 32'd10);
    Xready = 1'b1;
    step();

    // loop, Len=3, stop coincident with 7th handshake
    wr(0, 1); wr(1, 2); wr(2, 3);
    start_seq(3, 1);
    for (int i = 0; i < 6; i++) begin
      chk("loop_seq", 32'(Xout), 32'((i % 3) + 1));
      step();
    end
    chk("loop_seq7", 32'(Xout), 32'd1);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("loop_stop_done", 32'(Done), 32'd1);
    chk("loop_stop_sent", 32'(Sent), 32'd7);
    chk("loop_stop_xvalid", 32'(Xvalid), 32'd0);

    // Len=0 is ignored
    start_seq(0, 0);
    chk("len0_busy", 32'(Busy), 32'd0);
    step();
    chk("len0_done", 32'(Done), 32'd0);

    // Len=20 clamps to 16; Start mid-play ignored
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 255)));
    start_seq(20, 0);
    for (int i = 0; i < 5; i++) step();
    Start = 1'b1; Len = LW'(3);
    step();
    Start = 1'b0;
    for (int c = 0; c < 30 && !Done; c++) step();
    chk("len20_done", 32'(Done), 32'd1);
    chk("len20_sent", 32'(Sent), 32'd16);

    // write to the displayed entry while stalled
    wr(0, 8'h11);
    Xready = 1'b0;
    start_seq(4, 0);
    wr(0, 8'h55);
    step();
    chk("stall_hold", 32'(Xout), 32'h11);
    Xready = 1'b1;
    for (int c = 0; c < 10 && !Done; c++) step();
    chk("stall_done", 32'(Done), 32'd1);

    // reset mid-play clears buffer
    start_seq(16, 1);
    for (int i = 0; i < 3; i++) step();
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
    chk("midrst_xvalid", 32'(Xvalid), 32'd0);
    chk("midrst_sent", 32'(Sent), 32'd0);
    start_seq(16, 0);
    for (int i = 0; i < 16; i++) begin
      chk("midrst_zero", 32'(Xout), 32'd0);
      step();
    end

    // back-to-back restart in the Done cycle
    chk("b2b_done", 32'(Done), 32'd1);
    start_seq(2, 0);
    chk("b2b_busy", 32'(Busy), 32'd1);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      Rst_n   = ($urandom_range(0, 199) != 0);
      Wr_en   = ($urandom_range(0, 3) == 0);
      Wr_addr = AW'($urandom_range(0, DEPTH - 1));
      Wr_data = DW'($urandom_range(0, 255));
      Start   = ($urandom_range(0, 7) == 0);
      Len     = LW'($urandom_range(0, 31));
      Loop    = ($urandom_range(0, 1) == 1);
      Stop    = ($urandom_range(0, 15) == 0);
      Xready  = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
